// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter_gen ramp/SAR timing counter.
package counter_pkg;

  typedef enum logic {CTR_UP = 1'b0, CTR_DOWN = 1'b1} ctr_dir_e;

  localparam int CTR_WIDTH_DEF = 8;
  localparam int CTR_MAX_DEF   = (1 << CTR_WIDTH_DEF) - 1;
  localparam int CTR_CLAMP_W   = 32;

  // Limit a load value to the counter's terminal value.
  function automatic logic [CTR_CLAMP_W-1:0] ctr_clamp(
    input logic [CTR_CLAMP_W-1:0] setval,
    input logic [CTR_CLAMP_W-1:0] max
  );
    return (setval > max) ? max : setval;
  endfunction

endpackage

// File: rtl/counter_gen_cap_edge_det.sv
// Rising-edge detector with an optional input synchroniser, shared by
// comparator-facing blocks. SYNC_STAGES = 0 samples the input directly.
module cap_edge_det #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic s;
  logic hist_q;
  logic hist_d;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      always_comb begin
        sync_d[0] = in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign hist_d = s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 1'b0;
    else     hist_q <= hist_d;
  end

  assign rise = s & ~hist_q;

endmodule

// File: rtl/counter_gen.sv
// Parametrised up/down wrap/saturate counter with edge-triggered capture.
// Define COUNTER_CAP_SYNC_EN to pass cap through a 2-flop synchroniser.
import counter_pkg::*;

module counter_gen #(
  parameter int WIDTH    = CTR_WIDTH_DEF,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             set,
  input  logic [WIDTH-1:0] setval,
  input  logic             dir,
  input  logic             cap,
  input  logic             cap_clr,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             tc,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid
);

`ifdef COUNTER_CAP_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  ctr_dir_e         dir_e;
  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] cap_val_q, cap_val_d;
  logic             cap_valid_q, cap_valid_d;
  logic             cap_rise;

  assign dir_e = ctr_dir_e'(dir);

  cap_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cap_edge (
    .clk (clk),
    .rst (rst),
    .in  (cap),
    .rise(cap_rise)
  );

  // Load beats counting; a limit hit either wraps or holds but always pulses.
  always_comb begin
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (set) begin
      count_d = WIDTH'(ctr_clamp(CTR_CLAMP_W'(setval), CTR_CLAMP_W'(MAX_VAL)));
    end else if (en) begin
      if (dir_e == CTR_UP) begin
        if (count_q == MAX_W) begin
          overflow_d = 1'b1;
          count_d    = SATURATE ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          underflow_d = 1'b1;
          count_d     = SATURATE ? count_q : MAX_W;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Capture takes the pre-update count and wins over a simultaneous clear.
  always_comb begin
    cap_val_d   = cap_val_q;
    cap_valid_d = cap_valid_q;
    if (cap_rise) begin
      cap_val_d   = count_q;
      cap_valid_d = 1'b1;
    end else if (cap_clr) begin
      cap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      cap_val_q   <= cap_val_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign cap_val   = cap_val_q;
  assign cap_valid = cap_valid_q;
  assign tc        = ((dir_e == CTR_UP)   && (count_q == MAX_W)) ||
                     ((dir_e == CTR_DOWN) && (count_q == '0));

endmodule

// File: tb/tb_counter_gen.sv
// Self-checking bench for counter_gen: three configurations driven in parallel
// (wrap 0..255, wrap 0..9, saturate 0..255) against an arithmetic reference.
module tb_counter_gen;

`ifdef COUNTER_CAP_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, set, dir, cap, cap_clr;
  logic [7:0] setval;

  logic [7:0] cnt [3];
  logic [7:0] cv  [3];
  logic       ovf [3];
  logic       udf [3];
  logic       tcs [3];
  logic       cvld[3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_gen #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .set(set), .setval(setval), .dir(dir),
    .cap(cap), .cap_clr(cap_clr), .count(cnt[0]), .overflow(ovf[0]),
    .underflow(udf[0]), .tc(tcs[0]), .cap_val(cv[0]), .cap_valid(cvld[0]));

  counter_gen #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .set(set), .setval(setval), .dir(dir),
    .cap(cap), .cap_clr(cap_clr), .count(cnt[1]), .overflow(ovf[1]),
    .underflow(udf[1]), .tc(tcs[1]), .cap_val(cv[1]), .cap_valid(cvld[1]));

  counter_gen #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .set(set), .setval(setval), .dir(dir),
    .cap(cap), .cap_clr(cap_clr), .count(cnt[2]), .overflow(ovf[2]),
    .underflow(udf[2]), .tc(tcs[2]), .cap_val(cv[2]), .cap_valid(cvld[2]));

  // Reference model: plain integer arithmetic on the range 0..max.
  int mmax[3] = '{255, 9, 255};
  int msat[3] = '{0, 0, 1};
  int m_cnt[3], m_ovf[3], m_udf[3], m_cv[3], m_cvld[3];
  bit cap_h[4];
  bit cs_now, cs_prev, m_rise;
  int old_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_cv[i] = 0; m_cvld[i] = 0;
      end
      for (int k = 0; k < 4; k++) cap_h[k] = 1'b0;
    end else begin
      cs_now  = (SYNC_LAT == 0) ? cap : cap_h[SYNC_LAT];
      cs_prev = cap_h[SYNC_LAT + 1];
      m_rise  = cs_now && !cs_prev;
      cap_h[3] = cap_h[2]; cap_h[2] = cap_h[1]; cap_h[1] = cap;
      for (int i = 0; i < 3; i++) begin
        old_c = m_cnt[i];
        m_ovf[i] = 0;
        m_udf[i] = 0;
        if (set) begin
          m_cnt[i] = (int'(setval) > mmax[i]) ? mmax[i] : int'(setval);
        end else if (en && !dir) begin
          m_ovf[i] = (old_c == mmax[i]);
          m_cnt[i] = msat[i] ? ((old_c + 1 > mmax[i]) ? mmax[i] : old_c + 1)
                             : (old_c + 1) % (mmax[i] + 1);
        end else if (en && dir) begin
          m_udf[i] = (old_c == 0);
          m_cnt[i] = msat[i] ? ((old_c - 1 < 0) ? 0 : old_c - 1)
                             : (old_c + mmax[i]) % (mmax[i] + 1);
        end
        if (m_rise) begin
          m_cv[i] = old_c; m_cvld[i] = 1;
        end else if (cap_clr) begin
          m_cvld[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int etc;
    for (int i = 0; i < 3; i++) begin
      etc = ((!dir && m_cnt[i] == mmax[i]) || (dir && m_cnt[i] == 0)) ? 1 : 0;
      chk($sformatf("m%0d.count", i), int'(cnt[i]), m_cnt[i]);
      chk($sformatf("m%0d.overflow", i), int'(ovf[i]), m_ovf[i]);
      chk($sformatf("m%0d.underflow", i), int'(udf[i]), m_udf[i]);
      chk($sformatf("m%0d.tc", i), int'(tcs[i]), etc);
      chk($sformatf("m%0d.cap_val", i), int'(cv[i]), m_cv[i]);
      chk($sformatf("m%0d.cap_valid", i), int'(cvld[i]), m_cvld[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       set;
    logic [7:0] setval;
    logic       en;
    logic       dir;
    int ea, oa, ua, eb, ob, ub, ec, oc, uc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 8'd255, 1'b0, 1'b0, 255, 0, 0,   9, 0, 0, 255, 0, 0};
    tbl[1] = '{1'b0, 8'd0,   1'b1, 1'b0,   0, 1, 0,   0, 1, 0, 255, 1, 0};
    tbl[2] = '{1'b0, 8'd0,   1'b1, 1'b0,   1, 0, 0,   1, 0, 0, 255, 1, 0};
    tbl[3] = '{1'b1, 8'd0,   1'b0, 1'b0,   0, 0, 0,   0, 0, 0,   0, 0, 0};
    tbl[4] = '{1'b0, 8'd0,   1'b1, 1'b1, 255, 0, 1,   9, 0, 1,   0, 0, 1};
    tbl[5] = '{1'b0, 8'd0,   1'b1, 1'b1, 254, 0, 0,   8, 0, 0,   0, 0, 1};
    tbl[6] = '{1'b0, 8'd0,   1'b0, 1'b1, 254, 0, 0,   8, 0, 0,   0, 0, 0};

    rst = 1'b1; en = 0; set = 0; dir = 0; cap = 0; cap_clr = 0; setval = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", int'(cnt[0]), 0);
    chk("rst.overflow", int'(ovf[0]), 0);
    chk("rst.cap_valid", int'(cvld[0]), 0);
    rst = 1'b0;

    // Count up 37 then hold.
    en = 1; dir = 0;
    repeat (37) step();
    chk("up37.count", int'(cnt[0]), 37);
    chk("up37.overflow", int'(ovf[0]), 0);
    en = 0;
    repeat (2) step();
    chk("hold.count", int'(cnt[0]), 37);

    // Table: wrap, saturate and clamp across all three configurations.
    for (int v = 0; v < 7; v++) begin
      set = tbl[v].set; setval = tbl[v].setval; en = tbl[v].en; dir = tbl[v].dir;
      step();
      chk($sformatf("tbl%0d.a.count", v), int'(cnt[0]), tbl[v].ea);
      chk($sformatf("tbl%0d.a.ovf", v), int'(ovf[0]), tbl[v].oa);
      chk($sformatf("tbl%0d.a.udf", v), int'(udf[0]), tbl[v].ua);
      chk($sformatf("tbl%0d.b.count", v), int'(cnt[1]), tbl[v].eb);
      chk($sformatf("tbl%0d.b.ovf", v), int'(ovf[1]), tbl[v].ob);
      chk($sformatf("tbl%0d.b.udf", v), int'(udf[1]), tbl[v].ub);
      chk($sformatf("tbl%0d.c.count", v), int'(cnt[2]), tbl[v].ec);
      chk($sformatf("tbl%0d.c.ovf", v), int'(ovf[2]), tbl[v].oc);
      chk($sformatf("tbl%0d.c.udf", v), int'(udf[2]), tbl[v].uc);
    end

    // Modulus 10: 7 -> 8 -> 9 -> 0 with overflow on the wrap.
    set = 1; setval = 8'd7; en = 0; dir = 0;
    step();
    chk("mod10.load7", int'(cnt[1]), 7);
    set = 0; en = 1;
    step(); chk("mod10.8", int'(cnt[1]), 8);
    step(); chk("mod10.9", int'(cnt[1]), 9); chk("mod10.9.ovf", int'(ovf[1]), 0);
    step(); chk("mod10.0", int'(cnt[1]), 0); chk("mod10.0.ovf", int'(ovf[1]), 1);
    step(); chk("mod10.1.ovf", int'(ovf[1]), 0);
    set = 1; setval = 8'd200; en = 0;
    step(); chk("mod10.clamp200", int'(cnt[1]), 9);
    en = 1;
    step(); chk("mod10.set_en.count", int'(cnt[1]), 9);
    chk("mod10.set_en.ovf", int'(ovf[1]), 0);

    // Saturation at the top re-pulses every enabled cycle.
    set = 1; setval = 8'd255; en = 0;
    step();
    set = 0; en = 1; dir = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat.hold.count", int'(cnt[2]), 255);
      chk("sat.hold.ovf", int'(ovf[2]), 1);
    end
    dir = 1;
    step();
    chk("sat.down.count", int'(cnt[2]), 254);
    chk("sat.down.ovf", int'(ovf[2]), 0);

    // Capture sequence from a fresh reset.
    en = 0; dir = 0; cap = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    en = 1;
    repeat (20) step();
    cap = 1;
    step();
    repeat (SYNC_LAT) step();
    chk("cap.val", int'(cv[0]), 20 + SYNC_LAT);
    chk("cap.valid", int'(cvld[0]), 1);
    repeat (5) step();
    chk("cap.held.val", int'(cv[0]), 20 + SYNC_LAT);
    cap = 0; en = 0; cap_clr = 1;
    step();
    chk("cap.clr.valid", int'(cvld[0]), 0);
    cap_clr = 0;
    repeat (3) step();
    cap = 1;
    repeat (SYNC_LAT) step();
    cap_clr = 1;
    step();
    chk("cap.clr_vs_edge.valid", int'(cvld[0]), 1);
    chk("cap.clr_vs_edge.val", int'(cv[0]), 26 + SYNC_LAT);
    cap = 0; cap_clr = 0;
    repeat (3) step();

    // Reset in the middle of a capture.
    en = 1;
    cap = 1;
    step();
    #2 rst = 1;
    #1;
    chk("midrst.count", int'(cnt[0]), 0);
    chk("midrst.cap_val", int'(cv[0]), 0);
    chk("midrst.cap_valid", int'(cvld[0]), 0);
    @(posedge clk); #1;
    rst = 0; cap = 0;
    step();

    // Random traffic against the model.
    for (int r = 0; r < 400; r++) begin
      set     = ($urandom_range(0, 15) == 0);
      setval  = 8'($urandom);
      en      = ($urandom_range(0, 3) != 0);
      dir     = 1'($urandom_range(0, 1));
      cap     = ($urandom_range(0, 3) == 0);
      cap_clr = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_gen.md
Name: counter_gen

Overview:
Parametrised up/down counter for ramp and SAR timing in the ADC digital back end. It is the successor to the fixed 8-bit up counter. It adds:
- configurable width and modulus
- direction control
- optional saturation instead of wrap
- an edge-triggered capture register that latches the count when the comparator trips, for conversion results and side-channel timestamps.

Parameters:
WIDTH, 8, counter/setval/capture width in bits (>=2)
MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1)
SATURATE, 0, 0 = wrap at limits; 1 = hold at limits

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  count enable
set  in  1  synchronous load of setval (priority over en)
setval  in  WIDTH  load value
dir  in  1  0 = up, 1 = down
cap  in  1  capture strobe; rising edge captures count
cap_clr  in  1  clears cap_valid
count  out  WIDTH  registered count
overflow  out  1  registered one-cycle pulse, up-count limit event
underflow  out  1  registered one-cycle pulse, down-count limit event
tc  out  1  combinational terminal count: (dir==0 && count==MAX_VAL) || (dir==1 && count==0)
cap_val  out  WIDTH  captured count
cap_valid  out  1  sticky capture-done flag

Behaviour:
- Reset (async assert, sync-safe deassert by system): count=0, overflow=0, underflow=0, cap_val=0, cap_valid=0, edge-detect history=0. Reset mid-count aborts immediately; no pulse is emitted.
- Per-edge priority: set > en > hold.
  - set=1: count <= min(setval, MAX_VAL). overflow=underflow=0. Held while set stays high.
  - en=1, dir=0, count<MAX_VAL: count+1.
  - en=1, dir=1, count>0: count-1.
  - en=1, dir=0, count==MAX_VAL:
    - SATURATE=0: count <= 0, overflow=1.
    - SATURATE=1: count holds, overflow=1.
  - en=1, dir=1, count==0:
    - SATURATE=0: count <= MAX_VAL, underflow=1.
    - SATURATE=1: count holds, underflow=1.
  - en=0: count holds.
- overflow/underflow are high only in the cycle following the limit event. They re-pulse on every enabled limit cycle (relevant when saturating). They are never both high.
- Latency: count changes one cycle after en/set sampled high. overflow appears together with the wrapped count.
- set and a wrap in the same cycle: set wins, no pulse.
- Arithmetic is WIDTH bits. For MAX_VAL < 2**WIDTH-1, values above MAX_VAL are unreachable.
- Capture: rising edge = cap_s && !cap_s_q, where cap_s is the (optionally synchronised) cap.
  - On that edge: cap_val <= count (pre-update value of this cycle) and cap_valid <= 1.
  - cap_clr=1 clears cap_valid; a simultaneous capture edge wins (cap_valid stays 1, cap_val updates).
  - A new rising edge while cap_valid=1 overwrites cap_val.
  - cap held high causes only one capture.

Optional Feature:
Macro COUNTER_CAP_SYNC_EN.
- Defined: cap passes through a 2-flop synchroniser before edge detection. Capture occurs 2 cycles later than without the macro, and cap_val records the count at that later edge.
- Undefined: cap is sampled directly (synchronous source assumed). Capture occurs at the first edge where cap=1 and the previous sample was 0.
- Ports and reset values are identical in both builds.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {CTR_UP=1'b0, CTR_DOWN=1'b1} ctr_dir_e
  - localparam constants for the default WIDTH
  - function ctr_clamp(setval, max) returning min(setval, MAX_VAL)
- Sub-module cap_edge_det:
  - parameter SYNC_STAGES (0 or 2, chosen by the macro)
  - rst, clk, in, rise output
  - reused by other comparator-facing blocks

Test Plan:
- Reset → count=0, overflow=0, cap_valid=0. Then en=1, dir=0 for 37 cycles → count=37, no pulses. en=0 for 2 cycles → count holds at 37.
- WIDTH=8, SATURATE=0: set with setval=255, then en=1, dir=0 → count 0 with overflow=1 for one cycle, then 1 with overflow=0. set 0, dir=1 → count 255 with underflow=1.
- MAX_VAL=9, SATURATE=0:
  - count 7→8→9→0 with overflow on the 0.
  - setval=200 loads 9.
  - set=1 with en=1 at count 9 → count 9, no overflow.
- SATURATE=1, MAX_VAL=255, at 255 with en=1, dir=0 for 3 cycles → count stays 255, overflow high all 3 cycles. dir=1 → 254, overflow=0.
- Capture (no macro):
  - Counting up from 0, raise cap at the edge where count=20 → next cycle cap_val=20, cap_valid=1.
  - Hold cap high 5 cycles → no further capture.
  - cap_clr → cap_valid=0.
  - cap_clr together with a new edge → cap_valid stays 1.
- COUNTER_CAP_SYNC_EN build: same stimulus → cap_val=22, capture 2 cycles later. Assert rst mid-capture → cap_val=0, cap_valid=0, count=0.
